mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory arbiter.
//   arb_state_e         : arbiter FSM states (IDLE, I_WAIT, D_WAIT)
//   DEFAULT_BASE_ADDR   : default byte address of memory word 0
//   DEFAULT_DEPTH_WORDS : default memory depth in 32-bit words
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2
    } arb_state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h0000_1000;
    localparam int          DEFAULT_DEPTH_WORDS = 1024;

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous memory between a fetch port
// (i_*) and a data port (d_*).
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   i_req/i_addr         : fetch read request, byte address
//   i_gnt/i_rvalid/i_rdata : fetch grant, read data valid, read data
//   d_req/d_we/d_addr/d_wdata/d_wmask : data load/store request
//   d_gnt/d_rvalid/d_rdata : data grant, load data valid, load data
//   m_en/m_we/m_addr/m_wdata/m_rdata : memory port (m_rdata one cycle after a read)
//   err                  : one-cycle pulse after an out-of-range access
//   conflict_cnt         : saturating count of contended IDLE cycles
// Grants are combinational in IDLE only; a read spends one extra cycle in
// I_WAIT/D_WAIT to return its data, a store finishes in its grant cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_req,
    input  logic [31:0]                    i_addr,
    output logic                           i_gnt,
    output logic                           i_rvalid,
    output logic [31:0]                    i_rdata,
    input  logic                           d_req,
    input  logic                           d_we,
    input  logic [31:0]                    d_addr,
    input  logic [31:0]                    d_wdata,
    input  logic [3:0]                     d_wmask,
    output logic                           d_gnt,
    output logic                           d_rvalid,
    output logic [31:0]                    d_rdata,
    output logic                           m_en,
    output logic [3:0]                     m_we,
    output logic [$clog2(DEPTH_WORDS)-1:0] m_addr,
    output logic [31:0]                    m_wdata,
    input  logic [31:0]                    m_rdata,
    output logic                           err,
    output logic [15:0]                    conflict_cnt
);

    localparam int AW = $clog2(DEPTH_WORDS);

    arb_state_e  state_q, state_d;
    logic        last_d_q, last_d_d;   // 1 = data port won the most recent grant
    logic        rd_hit_q, rd_hit_d;   // the read in flight was in range
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;

    logic        gnt_i_s, gnt_d_s, contend_s, hit_s;
    logic [31:0] sel_addr_s;

    // Word-aligned range check; 33-bit math keeps the upper bound from wrapping.
    function automatic logic addr_in_range(input logic [31:0] a);
        logic [32:0] wa;
        logic [32:0] lo;
        logic [32:0] hi;
        wa = {1'b0, a} & ~33'd3;
        lo = {1'b0, BASE_ADDR};
        hi = lo + (33'(DEPTH_WORDS) << 2);
        return (wa >= lo) && (wa < hi);
    endfunction

    // Grant selection: only in IDLE and never while reset is asserted.
    always_comb begin
        gnt_i_s   = 1'b0;
        gnt_d_s   = 1'b0;
        contend_s = 1'b0;
        if ((state_q == IDLE) && !reset) begin
            contend_s = i_req && d_req;
            if (contend_s) begin
                // The port that did not win last time takes this one.
                if (last_d_q) begin
                    gnt_i_s = 1'b1;
                end else begin
                    gnt_d_s = 1'b1;
                end
            end else if (i_req) begin
                gnt_i_s = 1'b1;
            end else if (d_req) begin
                gnt_d_s = 1'b1;
            end else begin
                gnt_i_s = 1'b0;
            end
        end else begin
            contend_s = 1'b0;
        end
    end

    // Memory port drive for the granted request.
    always_comb begin
        sel_addr_s = gnt_d_s ? d_addr : i_addr;
        hit_s      = addr_in_range(sel_addr_s);
        m_en       = (gnt_i_s || gnt_d_s) && hit_s;
        m_we       = (gnt_d_s && d_we && hit_s) ? d_wmask : 4'b0000;
        m_addr     = AW'((sel_addr_s - BASE_ADDR) >> 2);
        m_wdata    = d_wdata;
    end

    // Next-state, grant history, error pulse and contention counter.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        rd_hit_d = rd_hit_q;
        err_d    = (gnt_i_s || gnt_d_s) && !hit_s;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (gnt_i_s) begin
                    state_d  = I_WAIT;
                    last_d_d = 1'b0;
                    rd_hit_d = hit_s;
                end else if (gnt_d_s) begin
                    last_d_d = 1'b1;
                    if (!d_we) begin
                        state_d  = D_WAIT;
                        rd_hit_d = hit_s;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            I_WAIT:  state_d = IDLE;
            D_WAIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (contend_s && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset discards any read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            rd_hit_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            rd_hit_q <= rd_hit_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Read return: out-of-range reads still complete, with zero data.
    always_comb begin
        i_gnt        = gnt_i_s;
        d_gnt        = gnt_d_s;
        i_rvalid     = (state_q == I_WAIT);
        d_rvalid     = (state_q == D_WAIT);
        i_rdata      = (i_rvalid && rd_hit_q) ? m_rdata : 32'h0;
        d_rdata      = (d_rvalid && rd_hit_q) ? m_rdata : 32'h0;
        err          = err_q;
        conflict_cnt = cnt_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Inputs change on the falling
// edge and outputs are checked 1 ns later. The memory model returns
// 32'hC0DE_0000 | word index one cycle after each enabled read.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_en;
    logic [3:0]  m_we;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = 32'h0;
    logic        err;
    logic [15:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_gnt        (i_gnt),
        .i_rvalid     (i_rvalid),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_wmask      (d_wmask),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .m_en         (m_en),
        .m_we         (m_we),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_rdata      (m_rdata),
        .err          (err),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous read memory: data appears the cycle after an enabled read.
    always @(posedge clk) begin
        if (m_en && (m_we == 4'b0000)) begin
            m_rdata <= 32'hC0DE_0000 | {22'b0, m_addr};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [5:0]  exp_ig, exp_dg, exp_irv, exp_drv;
    logic [15:0] exp_cnt [6];

    initial begin
        exp_ig  = 6'b000100;
        exp_dg  = 6'b010001;
        exp_irv = 6'b001000;
        exp_drv = 6'b100010;
        exp_cnt = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3};

        // Reset held with both ports requesting: nothing may be granted.
        reset = 1'b1; i_req = 1'b1; i_addr = 32'h1000;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000; d_wdata = 32'h0; d_wmask = 4'hF;
        @(negedge clk); #1;
        chk("rst_i_gnt", 32'(i_gnt), 32'd0);
        chk("rst_d_gnt", 32'(d_gnt), 32'd0);
        chk("rst_m_en", 32'(m_en), 32'd0);
        chk("rst_m_we", 32'(m_we), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cnt", 32'(conflict_cnt), 32'd0);
        chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        @(negedge clk);
        reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wmask = 4'h0;

        // Fetch alone.
        @(negedge clk); i_req = 1'b1; i_addr = 32'h1004; #1;
        chk("f_i_gnt", 32'(i_gnt), 32'd1);
        chk("f_m_en", 32'(m_en), 32'd1);
        chk("f_m_addr", 32'(m_addr), 32'd1);
        chk("f_m_we", 32'(m_we), 32'd0);
        @(negedge clk); i_req = 1'b0; #1;
        chk("f_i_rvalid", 32'(i_rvalid), 32'd1);
        chk("f_i_rdata", i_rdata, 32'hC0DE_0001);
        chk("f_wait_m_en", 32'(m_en), 32'd0);
        chk("f_d_rvalid", 32'(d_rvalid), 32'd0);
        @(negedge clk); #1;
        chk("f_i_rvalid_end", 32'(i_rvalid), 32'd0);
        chk("f_i_rdata_zero", i_rdata, 32'h0);

        // Store then load of the same word.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1008; d_wmask = 4'b0011; d_wdata = 32'hDEAD_BEEF; #1;
        chk("st_d_gnt", 32'(d_gnt), 32'd1);
        chk("st_m_en", 32'(m_en), 32'd1);
        chk("st_m_we", 32'(m_we), 32'b0011);
        chk("st_m_addr", 32'(m_addr), 32'd2);
        chk("st_m_wdata", m_wdata, 32'hDEAD_BEEF);
        @(negedge clk); d_we = 1'b0; d_wmask = 4'h0; #1;
        chk("st_no_rvalid", 32'(d_rvalid), 32'd0);
        chk("ld_d_gnt", 32'(d_gnt), 32'd1);
        chk("ld_m_we", 32'(m_we), 32'd0);
        chk("ld_m_addr", 32'(m_addr), 32'd2);
        @(negedge clk); d_req = 1'b0; #1;
        chk("ld_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("ld_d_rdata", d_rdata, 32'hC0DE_0002);
        chk("ld_wait_d_gnt", 32'(d_gnt), 32'd0);
        @(negedge clk); #1;
        chk("ld_d_rvalid_end", 32'(d_rvalid), 32'd0);

        // Fresh reset so the data port wins the first conflict.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;

        // Contention: both ports request reads for six cycles.
        @(negedge clk);
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h1010; d_addr = 32'h1020; d_we = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk($sformatf("ct%0d_i_gnt", c), 32'(i_gnt), 32'(exp_ig[c]));
            chk($sformatf("ct%0d_d_gnt", c), 32'(d_gnt), 32'(exp_dg[c]));
            chk($sformatf("ct%0d_i_rvalid", c), 32'(i_rvalid), 32'(exp_irv[c]));
            chk($sformatf("ct%0d_d_rvalid", c), 32'(d_rvalid), 32'(exp_drv[c]));
            chk($sformatf("ct%0d_i_rdata", c), i_rdata, exp_irv[c] ? 32'hC0DE_0004 : 32'h0);
            chk($sformatf("ct%0d_d_rdata", c), d_rdata, exp_drv[c] ? 32'hC0DE_0008 : 32'h0);
            chk($sformatf("ct%0d_cnt", c), 32'(conflict_cnt), 32'(exp_cnt[c]));
            if (exp_ig[c] || exp_dg[c]) begin
                chk($sformatf("ct%0d_m_addr", c), 32'(m_addr), exp_ig[c] ? 32'd4 : 32'd8);
            end
        end
        @(negedge clk); i_req = 1'b0; d_req = 1'b0; #1;
        chk("ct_cnt_final", 32'(conflict_cnt), 32'd3);

        // Out-of-range loads below and above the window.
        @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0FFC; #1;
        chk("lo_d_gnt", 32'(d_gnt), 32'd1);
        chk("lo_m_en", 32'(m_en), 32'd0);
        @(negedge clk); d_req = 1'b0; #1;
        chk("lo_err", 32'(err), 32'd1);
        chk("lo_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("lo_d_rdata", d_rdata, 32'h0);
        @(negedge clk); d_req = 1'b1; d_addr = 32'h2000; #1;
        chk("hi_err_pulse_end", 32'(err), 32'd0);
        chk("hi_d_gnt", 32'(d_gnt), 32'd1);
        chk("hi_m_en", 32'(m_en), 32'd0);
        @(negedge clk); d_req = 1'b0; #1;
        chk("hi_err", 32'(err), 32'd1);
        chk("hi_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("hi_d_rdata", d_rdata, 32'h0);

        // Last word of the window, low address bits set.
        @(negedge clk); d_req = 1'b1; d_addr = 32'h1FFF; #1;
        chk("top_m_en", 32'(m_en), 32'd1);
        chk("top_m_addr", 32'(m_addr), 32'd1023);
        @(negedge clk); d_req = 1'b0; #1;
        chk("top_err", 32'(err), 32'd0);
        chk("top_d_rdata", d_rdata, 32'hC0DE_03FF);

        // Out-of-range store is dropped and returns no data.
        @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wmask = 4'hF; #1;
        chk("ost_d_gnt", 32'(d_gnt), 32'd1);
        chk("ost_m_en", 32'(m_en), 32'd0);
        chk("ost_m_we", 32'(m_we), 32'd0);
        @(negedge clk); d_req = 1'b0; d_we = 1'b0; d_wmask = 4'h0; #1;
        chk("ost_err", 32'(err), 32'd1);
        chk("ost_d_rvalid", 32'(d_rvalid), 32'd0);

        // Reset asserted while a fetch read is waiting.
        @(negedge clk); i_req = 1'b1; i_addr = 32'h1000; #1;
        chk("rr_i_gnt", 32'(i_gnt), 32'd1);
        chk("rr_m_addr", 32'(m_addr), 32'd0);
        @(negedge clk); i_req = 1'b0; d_req = 1'b1; d_we = 1'b1; reset = 1'b1; #1;
        chk("rr_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("rr_i_rdata", i_rdata, 32'h0);
        chk("rr_cnt", 32'(conflict_cnt), 32'd0);
        chk("rr_d_gnt", 32'(d_gnt), 32'd0);
        chk("rr_m_en", 32'(m_en), 32'd0);
        @(negedge clk); reset = 1'b0; d_req = 1'b0; #1;
        chk("rr_no_rvalid", 32'(i_rvalid), 32'd0);
        @(negedge clk); i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1004; #1;
        chk("rr_first_d_gnt", 32'(d_gnt), 32'd1);
        chk("rr_first_i_gnt", 32'(i_gnt), 32'd0);
        @(negedge clk); #1;
        chk("rr_second_i_gnt", 32'(i_gnt), 32'd1);
        chk("rr_second_cnt", 32'(conflict_cnt), 32'd1);
        @(negedge clk); i_req = 1'b0; d_req = 1'b0; #1;
        chk("rr_i_rvalid2", 32'(i_rvalid), 32'd1);
        chk("rr_i_rdata2", i_rdata, 32'hC0DE_0000);
        chk("rr_cnt2", 32'(conflict_cnt), 32'd2);

        // Saturation: preload near the top, then keep contending.
        @(negedge clk);
        force dut.cnt_q = 16'hFFFD;
        #1;
        release dut.cnt_q;
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        chk("sat_reach", 32'(conflict_cnt), 32'h0000_FFFF);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
        end
        #1;
        chk("sat_hold", 32'(conflict_cnt), 32'h0000_FFFF);
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk); #1;
        chk("sat_idle", 32'(conflict_cnt), 32'h0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
